// File: rtl/sccb_cmd_master.sv
// Queued SCCB master: command FIFO feeding a quarter-bit sequenced
// SCL/SDA engine with 8/16-bit register addressing and optional ACK check.
module sccb_cmd_master #(
    parameter int ADDR_BYTES = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16,
    parameter bit CHECK_ACK  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] clk_div,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_wr,
    input  logic [7:0]       cmd_dev,
    input  logic [15:0]      cmd_addr,
    input  logic [7:0]       cmd_data,
    output logic             rd_valid,
    output logic [7:0]       rd_data,
    output logic             busy,
    output logic             err_nack,
    input  logic             err_clr,
    output logic             sccb_clk,
    output logic             sccb_clk_en,
    output logic             sccb_data_out,
    output logic             sccb_data_en,
    input  logic             sccb_data_in
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);
    localparam logic [1:0]  AB   = 2'(ADDR_BYTES);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_START  = 4'd1;
    localparam logic [3:0] S_TX     = 4'd2;
    localparam logic [3:0] S_ACK    = 4'd3;
    localparam logic [3:0] S_RSTOP  = 4'd4;
    localparam logic [3:0] S_RSTART = 4'd5;
    localparam logic [3:0] S_RX     = 4'd6;
    localparam logic [3:0] S_MNACK  = 4'd7;
    localparam logic [3:0] S_STOP   = 4'd8;

    logic [31:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]    wptr, rptr;
    logic [PW:0]      count;
    logic             push, pop;

    logic [3:0]       state;
    logic [1:0]       q, idx, last_idx;
    logic [2:0]       bcnt;
    logic             rd2, ack_bit, tick;
    logic [7:0]       rx_sh, tx_byte;
    logic [DIV_W-1:0] div_cnt, div_q;

    logic             c_wr;
    logic [6:0]       c_dev;
    logic [15:0]      c_addr;
    logic [7:0]       c_data;

    assign cmd_ready   = (count != FULL);
    assign push        = cmd_valid && cmd_ready;
    assign pop         = (state == S_IDLE) && (count != '0);
    assign busy        = (count != '0) || (state != S_IDLE);
    assign sccb_clk_en = (state != S_IDLE);
    assign tick        = (state != S_IDLE) && (div_cnt == div_q);
    assign last_idx    = c_wr ? AB + 2'd1 : AB;

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= {cmd_wr, cmd_dev[7:1], cmd_addr, cmd_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            if (push && !pop)      count <= count + (PW+1)'(1);
            else if (pop && !push) count <= count - (PW+1)'(1);
        end
    end

    // Divider reloads only at a tick, so clk_div changes land on tick boundaries.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            div_q   <= '0;
        end else if (state == S_IDLE || tick) begin
            div_cnt <= '0;
            div_q   <= clk_div;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_comb begin
        tx_byte = {c_dev, 1'b0};
        if (rd2) begin
            tx_byte = {c_dev, 1'b1};
        end else begin
            case (idx)
                2'd1:    tx_byte = (ADDR_BYTES == 2) ? c_addr[15:8] : c_addr[7:0];
                2'd2:    tx_byte = (ADDR_BYTES == 2) ? c_addr[7:0] : c_data;
                2'd3:    tx_byte = c_data;
                default: tx_byte = {c_dev, 1'b0};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        rd_valid <= 1'b0;
        if (rst) begin
            state    <= S_IDLE;
            q        <= '0;
            bcnt     <= '0;
            idx      <= '0;
            rd2      <= 1'b0;
            ack_bit  <= 1'b0;
            rx_sh    <= '0;
            rd_data  <= '0;
            err_nack <= 1'b0;
            c_wr     <= 1'b0;
            c_dev    <= '0;
            c_addr   <= '0;
            c_data   <= '0;
        end else begin
            if (err_clr) err_nack <= 1'b0;
            if (state == S_IDLE) begin
                q    <= '0;
                bcnt <= '0;
                idx  <= '0;
                rd2  <= 1'b0;
                if (pop) begin
                    state <= S_START;
                    {c_wr, c_dev, c_addr, c_data} <= mem[rptr];
                end
            end else if (tick) begin
                q <= q + 2'd1;
                if (q == 2'd2) begin
                    ack_bit <= sccb_data_in;
                    if (state == S_RX) rx_sh <= {rx_sh[6:0], sccb_data_in};
                    if (state == S_ACK && CHECK_ACK && sccb_data_in) err_nack <= 1'b1;
                end
                if (q == 2'd3) begin
                    case (state)
                        S_START: begin
                            state <= S_TX;
                            bcnt  <= '0;
                        end
                        S_RSTART: begin
                            state <= S_TX;
                            bcnt  <= '0;
                            rd2   <= 1'b1;
                        end
                        S_TX: begin
                            bcnt <= bcnt + 3'd1;
                            if (bcnt == 3'd7) state <= S_ACK;
                        end
                        S_ACK: begin
                            bcnt <= '0;
                            if (CHECK_ACK && ack_bit) state <= S_STOP;
                            else if (rd2)             state <= S_RX;
                            else if (idx == last_idx) state <= c_wr ? S_STOP : S_RSTOP;
                            else begin
                                idx   <= idx + 2'd1;
                                state <= S_TX;
                            end
                        end
                        S_RSTOP: state <= S_RSTART;
                        S_RX: begin
                            bcnt <= bcnt + 3'd1;
                            if (bcnt == 3'd7) state <= S_MNACK;
                        end
                        S_MNACK: begin
                            state    <= S_STOP;
                            bcnt     <= '0;
                            rd_data  <= rx_sh;
                            rd_valid <= 1'b1;
                        end
                        S_STOP: begin
                            bcnt <= bcnt + 3'd1;
                            if (bcnt[0]) state <= S_IDLE;
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end
        end
    end

    // STOP bit 1 is bus idle time: SCL held high, SDA released.
    always_comb begin
        sccb_clk      = 1'b1;
        sccb_data_out = 1'b1;
        sccb_data_en  = 1'b0;
        case (state)
            S_START, S_RSTART: begin
                sccb_clk      = (q != 2'd3);
                sccb_data_en  = 1'b1;
                sccb_data_out = ~q[1];
            end
            S_TX: begin
                sccb_clk      = q[1];
                sccb_data_en  = 1'b1;
                sccb_data_out = tx_byte[~bcnt];
            end
            S_ACK, S_RX: sccb_clk = q[1];
            S_MNACK: begin
                sccb_clk     = q[1];
                sccb_data_en = 1'b1;
            end
            S_RSTOP: begin
                sccb_clk      = (q != 2'd0);
                sccb_data_en  = 1'b1;
                sccb_data_out = q[1];
            end
            S_STOP: begin
                if (!bcnt[0]) begin
                    sccb_clk      = (q != 2'd0);
                    sccb_data_en  = 1'b1;
                    sccb_data_out = q[1];
                end
            end
            default: ;
        endcase
    end
endmodule
